// File: rtl/load_unit.sv
// rtl/load_unit.sv - RV32I load unit: word-aligned data-memory read, lane extract, sign/zero extend.
// Optional LOAD_TIMEOUT_EN raises an access fault when a read stalls for TIMEOUT_CYCLES in REQ.

module load_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_req_in,
    input  logic [2:0]  func3_in,
    input  logic [31:0] iadder_in,
    input  logic [4:0]  rd_addr_in,
    output logic        busy_out,
    output logic [31:0] dm_addr_out,
    output logic        dm_rd_req_out,
    input  logic        dm_rd_valid_in,
    input  logic [31:0] dm_data_in,
    output logic        load_valid_out,
    output logic [31:0] load_data_out,
    output logic [4:0]  load_rd_out,
    output logic        load_err_out,
    output logic [1:0]  err_code_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] CODE_MISALIGNED = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CODE_FAULT      = 2'b11;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
            $error("load_unit: TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    state_t      state;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic [31:0] lane;
    logic [31:0] ext_data;

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Request decode; an illegal func3 masks any misalignment.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        case (func3_in)
            F3_LB, F3_LBU: req_misaligned = 1'b0;
            F3_LH, F3_LHU: req_misaligned = iadder_in[0];
            F3_LW:         req_misaligned = (iadder_in[1:0] != 2'b00);
            default:       req_illegal    = 1'b1;
        endcase
    end

    always_comb begin
        lane     = dm_data_in >> {off_q, 3'b000};
        ext_data = lane;
        case (func3_q)
            F3_LB:   ext_data = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  ext_data = {24'd0, lane[7:0]};
            F3_LH:   ext_data = {{16{lane[15]}}, lane[15:0]};
            F3_LHU:  ext_data = {16'd0, lane[15:0]};
            default: ext_data = lane;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            func3_q        <= 3'd0;
            off_q          <= 2'd0;
            rd_q           <= 5'd0;
            busy_out       <= 1'b0;
            dm_addr_out    <= 32'd0;
            dm_rd_req_out  <= 1'b0;
            load_valid_out <= 1'b0;
            load_data_out  <= 32'd0;
            load_rd_out    <= 5'd0;
            load_err_out   <= 1'b0;
            err_code_out   <= 2'b00;
`ifdef LOAD_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            load_valid_out <= 1'b0;
            load_err_out   <= 1'b0;
            err_code_out   <= 2'b00;

            case (state)
                REQ: begin
                    // A response in the expiry cycle still completes normally.
                    if (dm_rd_valid_in) begin
                        state          <= RESP;
                        busy_out       <= 1'b0;
                        dm_rd_req_out  <= 1'b0;
                        load_valid_out <= 1'b1;
                        load_data_out  <= ext_data;
                        load_rd_out    <= rd_q;
                    end
`ifdef LOAD_TIMEOUT_EN
                    else if (tmo_cnt == CNT_LAST) begin
                        state         <= ERR;
                        busy_out      <= 1'b0;
                        dm_rd_req_out <= 1'b0;
                        load_err_out  <= 1'b1;
                        err_code_out  <= CODE_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    // IDLE, RESP and ERR all accept a new request.
                    if (load_req_in) begin
                        func3_q     <= func3_in;
                        off_q       <= iadder_in[1:0];
                        rd_q        <= rd_addr_in;
                        dm_addr_out <= {iadder_in[31:2], 2'b00};
`ifdef LOAD_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                        if (req_illegal) begin
                            state        <= ERR;
                            load_err_out <= 1'b1;
                            err_code_out <= CODE_ILLEGAL;
                        end else if (req_misaligned) begin
                            state        <= ERR;
                            load_err_out <= 1'b1;
                            err_code_out <= CODE_MISALIGNED;
                        end else begin
                            state         <= REQ;
                            busy_out      <= 1'b1;
                            dm_rd_req_out <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - scoreboard bench for load_unit; build with LOAD_TIMEOUT_EN to cover the fault path.

module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] iadder = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        busy;
    logic [31:0] dm_addr;
    logic        dm_rd_req;
    logic        dm_rd_valid = 1'b0;
    logic [31:0] dm_data = 32'd0;
    logic        load_valid;
    logic [31:0] load_data;
    logic [4:0]  load_rd;
    logic        load_err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];

    load_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .load_req_in    (load_req),
        .func3_in       (func3),
        .iadder_in      (iadder),
        .rd_addr_in     (rd_addr),
        .busy_out       (busy),
        .dm_addr_out    (dm_addr),
        .dm_rd_req_out  (dm_rd_req),
        .dm_rd_valid_in (dm_rd_valid),
        .dm_data_in     (dm_data),
        .load_valid_out (load_valid),
        .load_data_out  (load_data),
        .load_rd_out    (load_rd),
        .load_err_out   (load_err),
        .err_code_out   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every result or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (load_valid || load_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual valid=%0b err=%0b expected no output", load_valid, load_err);
            end else begin
                e = sb.pop_front();
                chk("sb_kind_err", {31'd0, load_err}, {31'd0, e.is_err});
                chk("sb_kind_valid", {31'd0, load_valid}, {31'd0, ~e.is_err});
                if (e.is_err) begin
                    chk("sb_err_code", {30'd0, err_code}, {30'd0, e.code});
                end else begin
                    chk("sb_load_data", load_data, e.data);
                    chk("sb_load_rd", {27'd0, load_rd}, {27'd0, e.rd});
                    chk("sb_code_zero", {30'd0, err_code}, 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        load_req = 1'b1;
        func3    = f3;
        iadder   = addr;
        rd_addr  = rd;
        step();
        load_req = 1'b0;
    endtask

    // Issue a load, hold REQ for 'waits' empty cycles, then return 'data'.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] data, input int waits, input logic [31:0] exp);
        sb.push_back('{1'b0, exp, rd, 2'b00});
        accept(f3, addr, rd);
        for (int w = 0; w <= waits; w++) begin
            chk("req_busy", {31'd0, busy}, 32'd1);
            chk("req_dm_rd_req", {31'd0, dm_rd_req}, 32'd1);
            chk("req_dm_addr", dm_addr, {addr[31:2], 2'b00});
            if (w == waits) begin
                dm_rd_valid = 1'b1;
                dm_data     = data;
            end
            step();
        end
        dm_rd_valid = 1'b0;
        dm_data     = 32'd0;
        chk("resp_valid", {31'd0, load_valid}, 32'd1);
        chk("resp_busy", {31'd0, busy}, 32'd0);
        chk("resp_dm_rd_req", {31'd0, dm_rd_req}, 32'd0);
    endtask

    task automatic run_err(input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] code);
        sb.push_back('{1'b1, 32'd0, 5'd0, code});
        accept(f3, addr, 5'd1);
        chk("err_pulse", {31'd0, load_err}, 32'd1);
        chk("err_no_req", {31'd0, dm_rd_req}, 32'd0);
        chk("err_not_busy", {31'd0, busy}, 32'd0);
        chk("err_no_valid", {31'd0, load_valid}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_dm_addr"}, dm_addr, 32'd0);
        chk({tag, "_dm_rd_req"}, {31'd0, dm_rd_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, load_valid}, 32'd0);
        chk({tag, "_data"}, load_data, 32'd0);
        chk({tag, "_rd"}, {27'd0, load_rd}, 32'd0);
        chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
        chk({tag, "_code"}, {30'd0, err_code}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        run_load(3'b000, 32'h0000_1003, 5'd5,  32'h80FF_1234, 0, 32'hFFFF_FF80);
        run_load(3'b101, 32'h0000_2002, 5'd7,  32'hBEEF_0001, 5, 32'h0000_BEEF);
        step();
        chk("hold_data_idle", load_data, 32'h0000_BEEF);
        chk("hold_rd_idle", {27'd0, load_rd}, 32'd7);
        run_load(3'b100, 32'h0000_0001, 5'd10, 32'h0000_A500, 1, 32'h0000_00A5);
        run_load(3'b000, 32'h0000_0000, 5'd11, 32'h1234_567F, 0, 32'h0000_007F);
        run_load(3'b001, 32'h0000_0000, 5'd12, 32'h0000_F0F0, 2, 32'hFFFF_F0F0);
        run_load(3'b010, 32'h0000_0004, 5'd31, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        run_load(3'b100, 32'h0000_0002, 5'd0,  32'h00FF_0000, 0, 32'h0000_00FF);
        run_load(3'b000, 32'h0000_0006, 5'd3,  32'h0080_0000, 3, 32'hFFFF_FF80);
        step();

        run_err(3'b010, 32'h0000_3001, 2'b01);
        run_err(3'b011, 32'h0000_0000, 2'b10);
        run_err(3'b001, 32'h0000_0005, 2'b01);
        run_err(3'b111, 32'h0000_0001, 2'b10);
        step();

        // Back-to-back: second load accepted in the first load's RESP cycle.
        sb.push_back('{1'b0, 32'h1122_3344, 5'd8, 2'b00});
        sb.push_back('{1'b0, 32'hFFFF_8001, 5'd9, 2'b00});
        accept(3'b010, 32'h0000_0010, 5'd8);
        dm_rd_valid = 1'b1;
        dm_data     = 32'h1122_3344;
        step();
        dm_rd_valid = 1'b0;
        chk("b2b_first_valid", {31'd0, load_valid}, 32'd1);
        accept(3'b001, 32'h0000_0012, 5'd9);
        chk("b2b_second_busy", {31'd0, busy}, 32'd1);
        chk("b2b_second_req", {31'd0, dm_rd_req}, 32'd1);
        chk("b2b_second_addr", dm_addr, 32'h0000_0010);
        dm_rd_valid = 1'b1;
        dm_data     = 32'h8001_7FFF;
        step();
        dm_rd_valid = 1'b0;
        chk("b2b_second_valid", {31'd0, load_valid}, 32'd1);
        step();

        // Reset while a read is outstanding, then a stale response in IDLE.
        accept(3'b000, 32'h0000_0040, 5'd2);
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("rst_mid_req");
        dm_rd_valid = 1'b1;
        dm_data     = 32'hFFFF_FFFF;
        step();
        dm_rd_valid = 1'b0;
        chk_all_zero("stale_valid");
        step();

`ifdef LOAD_TIMEOUT_EN
        sb.push_back('{1'b1, 32'd0, 5'd0, 2'b11});
        accept(3'b010, 32'h0000_0050, 5'd4);
        for (int c = 0; c < 4; c++) begin
            chk("tmo_req_held", {31'd0, dm_rd_req}, 32'd1);
            step();
        end
        chk("tmo_fault_pulse", {31'd0, load_err}, 32'd1);
        chk("tmo_req_dropped", {31'd0, dm_rd_req}, 32'd0);
        step();

        sb.push_back('{1'b0, 32'hCAFE_F00D, 5'd6, 2'b00});
        accept(3'b010, 32'h0000_0060, 5'd6);
        repeat (3) step();
        chk("tmo_last_req", {31'd0, dm_rd_req}, 32'd1);
        dm_rd_valid = 1'b1;
        dm_data     = 32'hCAFE_F00D;
        step();
        dm_rd_valid = 1'b0;
        chk("tmo_edge_valid", {31'd0, load_valid}, 32'd1);
        chk("tmo_edge_no_err", {31'd0, load_err}, 32'd0);
        step();
`else
        // Without the timeout a read may stall well past TIMEOUT_CYCLES.
        run_load(3'b010, 32'h0000_0060, 5'd6, 32'hCAFE_F00D, 10, 32'hCAFE_F00D);
        step();
`endif

        repeat (2) step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
